// File: rtl/counter_pkg.sv
// Shared types and constants for the cascaded multi-mode counter.
// The mode encoding is also the on-wire encoding of the mode port.
package counter_pkg;

   typedef enum logic [1:0] {
      WRAP     = 2'd0,
      SATURATE = 2'd1,
      ONESHOT  = 2'd2,
      HOLD     = 2'd3
   } mode_t;

   // Increment styles; both give identical behaviour.
   localparam int IMPL_CARRY = 0;
   localparam int IMPL_MUX   = 1;

   function automatic bit impl_valid(input int impl);
      return (impl == IMPL_CARRY) || (impl == IMPL_MUX);
   endfunction

endpackage

// File: rtl/counter_stage.sv
// One channel of the cascade: registered count and one-shot flag, plus a
// Mealy terminal pulse that feeds the enable of the next channel.
module counter_stage
   import counter_pkg::*;
#(
   parameter int WIDTH          = 16,
   parameter int IMPLEMENTATION = IMPL_CARRY
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_val,
   input  logic [WIDTH-1:0] max,
   input  mode_t            mode,
   output logic [WIDTH-1:0] cnt,
   output logic             pls,
   output logic             done
);

   logic             tc;
   logic [WIDTH-1:0] inc;

   assign tc = (cnt == max);

   generate
      if (IMPLEMENTATION == IMPL_MUX) begin : g_mux
         always_comb begin
            inc = cnt;
            if (en) inc = cnt + WIDTH'(1);
         end
      end else begin : g_carry
         assign inc = cnt + WIDTH'(en);
      end
   endgenerate

   // No pulse may escape while the stage is being reset, cleared or loaded.
   always_comb begin
      pls = 1'b0;
      if (!rst && !clr && !ld && en) begin
         unique case (mode)
            WRAP, SATURATE: pls = tc;
            ONESHOT:        pls = tc && !done;
            default:        pls = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt  <= '0;
         done <= 1'b0;
      end else if (ld) begin
         cnt  <= ld_val;
         done <= 1'b0;
      end else if (en) begin
         unique case (mode)
            WRAP: begin
               if (tc) cnt <= '0;
               else    cnt <= inc;
            end
            SATURATE: begin
               if (!tc) cnt <= inc;
            end
            ONESHOT: begin
               if (!done) begin
                  if (tc) done <= 1'b1;
                  else    cnt  <= inc;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/counter_cascade.sv
// Chain of CHANNELS counter stages; each stage's terminal pulse enables the
// next, so the pulse ripples combinationally from stage 0 to the last stage.
module counter_cascade
   import counter_pkg::*;
#(
   parameter int WIDTH          = 16,
   parameter int CHANNELS       = 4,
   parameter int IMPLEMENTATION = IMPL_CARRY
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            ena,
   input  logic                            clr,
   input  logic                            ld,
   input  logic [CHANNELS-1:0][WIDTH-1:0]  ld_val,
   input  logic [CHANNELS-1:0][WIDTH-1:0]  max,
   input  logic [CHANNELS-1:0][1:0]        mode,
   output logic [CHANNELS-1:0][WIDTH-1:0]  cnt,
   output logic [CHANNELS-1:0]             pls,
   output logic [CHANNELS-1:0]             done,
   output logic                            all
);

   generate
      if (!impl_valid(IMPLEMENTATION)) begin : g_bad_impl
         $fatal(1, "counter_cascade: IMPLEMENTATION must be 0 or 1");
      end

      for (genvar i = 0; i < CHANNELS; i++) begin : g_stage
         logic             en_s;
         logic             pls_s;
         logic             done_s;
         logic [WIDTH-1:0] cnt_s;

         // Per-block enable keeps the ripple path free of a self-referencing vector.
         if (i == 0) begin : g_first
            assign en_s = ena;
         end else begin : g_next
            assign en_s = g_stage[i-1].pls_s;
         end

         counter_stage #(
            .WIDTH          (WIDTH),
            .IMPLEMENTATION (IMPLEMENTATION)
         ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .en     (en_s),
            .clr    (clr),
            .ld     (ld),
            .ld_val (ld_val[i]),
            .max    (max[i]),
            .mode   (mode_t'(mode[i])),
            .cnt    (cnt_s),
            .pls    (pls_s),
            .done   (done_s)
         );

         assign cnt[i]  = cnt_s;
         assign pls[i]  = pls_s;
         assign done[i] = done_s;
      end
   endgenerate

   assign all = pls[CHANNELS-1];

endmodule
